rgb_pwm_fader: RTL

Parametrised N-channel PWM LED driver, successor to the fixed on/off RGB LED drive. It generates a per-channel duty cycle from the HFOSC-derived system clock and adds an optional linear fade mode per channel. Outputs are active-high "LED on" bits that feed the DOUT0 inputs of the SB_IO_OD open-drain pin instances in the top level.

---
 rtl/rgb_pwm_fader.sv | 117 +++++++++++
 1 files changed

// File: rtl/rgb_pwm_fader.sv
// N-channel PWM LED driver with per-channel linear fade toward a target duty.
// Duty is double-buffered into a shadow register at each PWM period boundary.
module rgb_pwm_fader #(
    parameter int CHANNELS     = 3,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 188,
    parameter int FADE_PERIODS = 4
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [2:0]          wr_ch,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic                wr_fade,
    output logic [CHANNELS-1:0] leds,
    output logic                period_start,
    output logic                busy
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FD_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [FD_W-1:0]     FD_MAX  = FD_W'(FADE_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FD_W-1:0]     fade_cnt_q, fade_cnt_d;
    logic [PWM_BITS-1:0] target_q [CHANNELS];
    logic [PWM_BITS-1:0] target_d [CHANNELS];
    logic [PWM_BITS-1:0] cur_q    [CHANNELS];
    logic [PWM_BITS-1:0] cur_d    [CHANNELS];
    logic [PWM_BITS-1:0] shadow_q [CHANNELS];
    logic [PWM_BITS-1:0] shadow_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] leds_q, leds_d;
    logic                period_start_q, period_start_d;
    logic                busy_q, busy_d;

    logic pwm_tick;
    logic pwm_wrap;
    logic fade_step;
    logic wr_hit;

    always_comb begin
        pwm_tick  = (presc_q == PS_MAX);
        pwm_wrap  = pwm_tick && (pwm_cnt_q == CNT_MAX);
        fade_step = period_start_q && (fade_cnt_q == FD_MAX);

        presc_d        = pwm_tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d      = pwm_tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        period_start_d = pwm_wrap;
        fade_cnt_d     = fade_cnt_q;
        if (period_start_q) begin
            fade_cnt_d = fade_step ? '0 : fade_cnt_q + 1'b1;
        end

        mode_d = mode_q;
        leds_d = '0;
        busy_d = 1'b0;
        wr_hit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            target_d[i] = target_q[i];
            cur_d[i]    = cur_q[i];
            // Shadow samples cur before any same-edge write lands.
            shadow_d[i] = pwm_wrap ? cur_q[i] : shadow_q[i];
            leds_d[i]   = enable && (pwm_cnt_q < shadow_q[i]);
            busy_d      = busy_d | (cur_q[i] != target_q[i]);
            wr_hit      = wr_en && (wr_ch == 3'(i));
            if (wr_hit) begin
                target_d[i] = wr_duty;
                mode_d[i]   = wr_fade;
                if (!wr_fade) begin
                    cur_d[i] = wr_duty;
                end
            end else if (fade_step && mode_q[i] && (cur_q[i] != target_q[i])) begin
                if (cur_q[i] < target_q[i]) begin
                    cur_d[i] = cur_q[i] + 1'b1;
                end else begin
                    cur_d[i] = cur_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            fade_cnt_q     <= '0;
            target_q       <= '{default: '0};
            cur_q          <= '{default: '0};
            shadow_q       <= '{default: '0};
            mode_q         <= '0;
            leds_q         <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            fade_cnt_q     <= fade_cnt_d;
            target_q       <= target_d;
            cur_q          <= cur_d;
            shadow_q       <= shadow_d;
            mode_q         <= mode_d;
            leds_q         <= leds_d;
            period_start_q <= period_start_d;
            busy_q         <= busy_d;
        end
    end

    assign leds         = leds_q;
    assign period_start = period_start_q;
    assign busy         = busy_q;

endmodule
